// File: rtl/avalon_seq_alu_pkg.sv
// Shared types and constants for the Avalon-MM sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_ILL = 3'd7
    } opcode_e;

    localparam logic [2:0] A_OPA    = 3'd0;
    localparam logic [2:0] A_OPB    = 3'd1;
    localparam logic [2:0] A_OP     = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_RES_LO = 3'd4;
    localparam logic [2:0] A_RES_HI = 3'd5;
    localparam logic [2:0] A_IRQ_EN = 3'd6;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DZ   = 2;
    localparam int ST_ERR  = 3;
    localparam int ST_BERR = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/avalon_seq_alu_if.sv
// Avalon-MM slave bus bundle for the sequential ALU.
interface avalon_seq_alu_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_write;
    logic [31:0]       avs_write_data;
    logic              avs_read;
    logic [31:0]       avs_read_data;
    logic              avs_readdatavalid;

    modport slave (
        input  avs_address, avs_write, avs_write_data, avs_read,
        output avs_read_data, avs_readdatavalid
    );

    modport master (
        output avs_address, avs_write, avs_write_data, avs_read,
        input  avs_read_data, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
//   state  | meaning
//   S_IDLE | waiting for i_start, operands loaded on start
//   S_RUN  | iterating, r_cnt counts DATA_W-1 down to 0
// o_lo/o_hi show the value the product/quotient register takes on this edge,
// so the parent can latch the final result on the same edge o_done is high.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);
    localparam int CNT_W = $clog2(DATA_W);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic [DATA_W-1:0]   r_b;
    logic [2*DATA_W-1:0] r_p;
    logic [2*DATA_W-1:0] w_p_step;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_sub;
    logic                w_div_ge;

    // One iteration of either algorithm; r_p holds {acc, multiplier} or {rem, quotient}.
    always_comb begin
        w_mul_sum   = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_p[2*DATA_W-1:DATA_W], r_p[DATA_W-1]};
        w_div_sub   = w_div_shift - {1'b0, r_b};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_p_step    = '0;
        if (r_is_div) begin
            w_p_step[2*DATA_W-1:DATA_W] = w_div_ge ? w_div_sub[DATA_W-1:0]
                                                   : w_div_shift[DATA_W-1:0];
            w_p_step[DATA_W-1:0]        = {r_p[DATA_W-2:0], w_div_ge};
        end else begin
            w_p_step = {w_mul_sum, r_p[DATA_W-1:1]};
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus operand load and per-cycle datapath update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_b      <= '0;
            r_p      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_p      <= {{DATA_W{1'b0}}, i_a};
                r_b      <= i_b;
                r_is_div <= i_is_div;
                r_cnt    <= CNT_W'(DATA_W - 1);
            end else if (r_state == S_RUN) begin
                r_p   <= w_p_step;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_RUN) && (r_cnt == '0);
    assign o_lo   = w_p_step[DATA_W-1:0];
    assign o_hi   = w_p_step[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/avalon_seq_alu.sv
// Memory-mapped ALU coprocessor: bus decode, operand/result registers, STATUS and irq.
module avalon_seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    avalon_seq_alu_if.slave        avs,
    output logic                   irq
);
    logic [DATA_W-1:0] r_opa, r_opb, r_res_lo, r_res_hi;
    logic              r_irq_en, r_done, r_dz, r_err, r_berr;
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic              w_busy, w_done;
    logic [DATA_W-1:0] w_lo, w_hi, w_wdata;
    logic [DATA_W:0]   w_add, w_sub;
    opcode_e           w_op;
    logic              w_hit_opa, w_hit_opb, w_hit_op, w_hit_status, w_hit_irq_en;
    logic              w_cfg_wr, w_op_go, w_b_zero, w_start;
    logic [4:0]        w_status;
    logic [31:0]       w_rdata;

    assign w_wdata      = avs.avs_write_data[DATA_W-1:0];
    assign w_op         = opcode_e'(avs.avs_write_data[2:0]);
    assign w_hit_opa    = avs.avs_address == ADDR_W'(A_OPA);
    assign w_hit_opb    = avs.avs_address == ADDR_W'(A_OPB);
    assign w_hit_op     = avs.avs_address == ADDR_W'(A_OP);
    assign w_hit_status = avs.avs_address == ADDR_W'(A_STATUS);
    assign w_hit_irq_en = avs.avs_address == ADDR_W'(A_IRQ_EN);
    assign w_cfg_wr     = avs.avs_write & (w_hit_opa | w_hit_opb | w_hit_op | w_hit_irq_en);
    assign w_op_go      = avs.avs_write & w_hit_op & ~w_busy;
    assign w_b_zero     = (r_opb == '0);
    assign w_start      = w_op_go & ((w_op == OP_MUL) | ((w_op == OP_DIV) & ~w_b_zero));
    assign w_add        = {1'b0, r_opa} + {1'b0, r_opb};
    assign w_sub        = {1'b0, r_opa} - {1'b0, r_opb};

    seq_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_is_div (w_op == OP_DIV),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_lo     (w_lo),
        .o_hi     (w_hi)
    );

    // Register writes, op launch and STATUS flags; later assignments win, so set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_err    <= 1'b0;
            r_berr   <= 1'b0;
        end else begin
            if (avs.avs_write && !w_busy) begin
                if (w_hit_opa)    r_opa    <= w_wdata;
                if (w_hit_opb)    r_opb    <= w_wdata;
                if (w_hit_irq_en) r_irq_en <= avs.avs_write_data[0];
            end
            if (avs.avs_write && w_hit_status) begin
                r_done <= 1'b0;
                r_dz   <= 1'b0;
                r_err  <= 1'b0;
                r_berr <= 1'b0;
            end
            if (w_cfg_wr && w_busy) r_berr <= 1'b1;
            if (w_op_go) begin
                r_done <= 1'b0;
                case (w_op)
                    OP_ADD: begin
                        r_res_lo <= w_add[DATA_W-1:0];
                        r_res_hi <= DATA_W'(w_add[DATA_W]);
                        r_done   <= 1'b1;
                    end
                    OP_SUB: begin
                        r_res_lo <= w_sub[DATA_W-1:0];
                        r_res_hi <= DATA_W'(w_sub[DATA_W]);
                        r_done   <= 1'b1;
                    end
                    OP_AND: begin
                        r_res_lo <= r_opa & r_opb;
                        r_res_hi <= '0;
                        r_done   <= 1'b1;
                    end
                    OP_OR: begin
                        r_res_lo <= r_opa | r_opb;
                        r_res_hi <= '0;
                        r_done   <= 1'b1;
                    end
                    OP_XOR: begin
                        r_res_lo <= r_opa ^ r_opb;
                        r_res_hi <= '0;
                        r_done   <= 1'b1;
                    end
                    OP_MUL: ;
                    OP_DIV: begin
                        if (w_b_zero) begin
                            r_res_lo <= '1;
                            r_res_hi <= r_opa;
                            r_dz     <= 1'b1;
                            r_done   <= 1'b1;
                        end
                    end
                    OP_ILL: begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end
                endcase
            end
            if (w_done) begin
                r_res_lo <= w_lo;
                r_res_hi <= w_hi;
                r_done   <= 1'b1;
            end
        end
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        w_status           = '0;
        w_status[ST_BUSY]  = w_busy;
        w_status[ST_DONE]  = r_done;
        w_status[ST_DZ]    = r_dz;
        w_status[ST_ERR]   = r_err;
        w_status[ST_BERR]  = r_berr;
        w_rdata            = '0;
        case (avs.avs_address)
            ADDR_W'(A_OPA):    w_rdata = 32'(r_opa);
            ADDR_W'(A_OPB):    w_rdata = 32'(r_opb);
            ADDR_W'(A_STATUS): w_rdata = 32'(w_status);
            ADDR_W'(A_RES_LO): w_rdata = 32'(r_res_lo);
            ADDR_W'(A_RES_HI): w_rdata = 32'(r_res_hi);
            ADDR_W'(A_IRQ_EN): w_rdata = 32'(r_irq_en);
            default:           w_rdata = '0;
        endcase
    end

    // Registered read data with a one-cycle valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= avs.avs_read;
            if (avs.avs_read) r_rdata <= w_rdata;
        end
    end

    assign avs.avs_read_data     = r_rdata;
    assign avs.avs_readdatavalid = r_rvalid;
    assign irq                   = r_irq_en & r_done;

endmodule

// File: tb/tb_avalon_seq_alu.sv
// Scoreboard bench: stimulus queues expected read data / irq levels, one monitor checks them.
module tb_avalon_seq_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic irq32, irq8;

    always #5 clk = ~clk;

    avalon_seq_alu_if #(.ADDR_W(3)) b32 ();
    avalon_seq_alu_if #(.ADDR_W(3)) b8 ();

    avalon_seq_alu #(.DATA_W(32), .ADDR_W(3)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .avs (b32),
        .irq (irq32)
    );

    avalon_seq_alu #(.DATA_W(8), .ADDR_W(3)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .avs (b8),
        .irq (irq8)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        string name;
        logic  exp;
    } irq_exp_t;

    rd_exp_t  q0[$];
    rd_exp_t  q1[$];
    irq_exp_t qi[$];

    int   errors   = 0;
    int   checks   = 0;
    int   cyc_cnt  = 0;
    bit   stim_done = 1'b0;
    logic prev_rd0 = 1'b0;
    logic prev_rd1 = 1'b0;

    always @(posedge clk) begin
        prev_rd0 <= b32.avs_read;
        prev_rd1 <= b8.avs_read;
    end

    // Monitor: all comparisons and the summary happen here.
    always @(negedge clk) begin : monitor
        rd_exp_t  e;
        irq_exp_t ie;
        cyc_cnt++;
        if (b32.avs_readdatavalid || prev_rd0) begin
            checks++;
            if (b32.avs_readdatavalid !== prev_rd0) begin
                errors++;
                $display("FAIL rvalid_timing_w32: got %b want %b", b32.avs_readdatavalid, prev_rd0);
            end
        end
        if (b32.avs_readdatavalid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid_w32: data %h with no read pending", b32.avs_read_data);
            end else begin
                e = q0.pop_front();
                if (b32.avs_read_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, b32.avs_read_data, e.exp);
                end
            end
        end
        if (b8.avs_readdatavalid || prev_rd1) begin
            checks++;
            if (b8.avs_readdatavalid !== prev_rd1) begin
                errors++;
                $display("FAIL rvalid_timing_w8: got %b want %b", b8.avs_readdatavalid, prev_rd1);
            end
        end
        if (b8.avs_readdatavalid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid_w8: data %h with no read pending", b8.avs_read_data);
            end else begin
                e = q1.pop_front();
                if (b8.avs_read_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, b8.avs_read_data, e.exp);
                end
            end
        end
        while (qi.size() > 0) begin
            ie = qi.pop_front();
            checks++;
            if (irq32 !== ie.exp) begin
                errors++;
                $display("FAIL %s: irq got %b want %b", ie.name, irq32, ie.exp);
            end
        end
        if (stim_done || cyc_cnt > 5000) begin
            if (!stim_done) begin
                checks++;
                errors++;
                $display("FAIL watchdog: stimulus still running after %0d cycles", cyc_cnt);
            end
            while (q0.size() > 0) begin
                e = q0.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: no read response, want %h", e.name, e.exp);
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: no read response, want %h", e.name, e.exp);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic drive(input int sel, input bit do_rd, input bit do_wr,
                         input logic [2:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            b32.avs_read       = do_rd;
            b32.avs_write      = do_wr;
            b32.avs_address    = addr;
            b32.avs_write_data = data;
        end else begin
            b8.avs_read        = do_rd;
            b8.avs_write       = do_wr;
            b8.avs_address     = addr;
            b8.avs_write_data  = data;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic push_exp(input int sel, input logic [31:0] exp, input string nm);
        rd_exp_t e;
        e.name = nm;
        e.exp  = exp;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic bus_wr(input int sel, input logic [2:0] addr, input logic [31:0] data);
        drive(sel, 1'b0, 1'b1, addr, data);
        step();
    endtask

    task automatic bus_rd(input int sel, input logic [2:0] addr, input logic [31:0] exp,
                          input string nm);
        drive(sel, 1'b1, 1'b0, addr, 32'd0);
        push_exp(sel, exp, nm);
        step();
    endtask

    task automatic bus_rdwr(input int sel, input logic [2:0] addr, input logic [31:0] data,
                            input logic [31:0] exp, input string nm);
        drive(sel, 1'b1, 1'b1, addr, data);
        push_exp(sel, exp, nm);
        step();
    endtask

    task automatic exp_irq(input logic v, input string nm);
        irq_exp_t ie;
        ie.name = nm;
        ie.exp  = v;
        qi.push_back(ie);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int a = 0; a < 8; a++) bus_rd(0, 3'(a), 32'd0, "reset_read");
        exp_irq(1'b0, "reset_irq");

        bus_wr(0, A_OPA, 32'd42);
        bus_wr(0, A_OPB, 32'd20);
        bus_wr(0, A_OP, 32'd0);
        bus_rd(0, A_RES_LO, 32'd62, "add_lo");
        bus_rd(0, A_RES_HI, 32'd0, "add_hi");
        bus_rd(0, A_STATUS, 32'h02, "add_status");

        bus_wr(0, A_OPA, 32'd20);
        bus_wr(0, A_OPB, 32'd42);
        bus_wr(0, A_OP, 32'd1);
        bus_rd(0, A_RES_LO, 32'hFFFF_FFEA, "sub_lo");
        bus_rd(0, A_RES_HI, 32'd1, "sub_borrow");

        bus_wr(0, A_OPA, 32'hF0F0_1234);
        bus_wr(0, A_OPB, 32'h0FF0_FF00);
        bus_wr(0, A_OP, 32'd2);
        bus_rd(0, A_RES_LO, 32'h00F0_1200, "and_lo");
        bus_rd(0, A_RES_HI, 32'd0, "and_hi");
        bus_wr(0, A_OP, 32'd3);
        bus_rd(0, A_RES_LO, 32'hFFF0_FF34, "or_lo");
        bus_wr(0, A_OP, 32'd4);
        bus_rd(0, A_RES_LO, 32'hFF00_ED34, "xor_lo");

        bus_wr(0, A_STATUS, 32'd0);
        bus_rd(0, A_STATUS, 32'h00, "status_clear");
        bus_wr(0, A_IRQ_EN, 32'd1);
        bus_rd(0, A_IRQ_EN, 32'd1, "irq_en_rb");
        exp_irq(1'b0, "irq_low_no_done");
        bus_wr(0, A_OPA, 32'hFFFF_FFFF);
        bus_wr(0, A_OPB, 32'd2);
        bus_wr(0, A_OP, 32'd5);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) bus_wr(0, A_OPA, 32'd7);
            else        bus_rd(0, A_STATUS, (i > 5) ? 32'h11 : 32'h01, "mul_busy");
            if (i == 10) exp_irq(1'b0, "mul_irq_busy");
        end
        bus_rd(0, A_STATUS, 32'h12, "mul_done_status");
        exp_irq(1'b1, "mul_irq_done");
        bus_rd(0, A_RES_LO, 32'hFFFF_FFFE, "mul_lo");
        bus_rd(0, A_RES_HI, 32'd1, "mul_hi");
        bus_rd(0, A_OPA, 32'hFFFF_FFFF, "berr_opa_kept");
        bus_wr(0, A_STATUS, 32'd0);
        exp_irq(1'b0, "irq_status_clear");
        bus_rd(0, A_STATUS, 32'h00, "status_clear2");

        bus_wr(0, A_OPA, 32'd42);
        bus_wr(0, A_OPB, 32'd5);
        bus_wr(0, A_OP, 32'd6);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) bus_wr(0, A_STATUS, 32'd0);
            else         bus_rd(0, A_STATUS, 32'h01, "div_busy");
        end
        bus_rd(0, A_STATUS, 32'h02, "div_done_beats_clear");
        exp_irq(1'b1, "div_irq_done");
        bus_rd(0, A_RES_LO, 32'd8, "div_quot");
        bus_rd(0, A_RES_HI, 32'd2, "div_rem");

        bus_wr(0, A_OPB, 32'd0);
        bus_wr(0, A_OP, 32'd6);
        bus_rd(0, A_STATUS, 32'h06, "dz_status");
        bus_rd(0, A_RES_LO, 32'hFFFF_FFFF, "dz_lo");
        bus_rd(0, A_RES_HI, 32'd42, "dz_hi");

        bus_wr(0, A_OP, 32'd7);
        bus_rd(0, A_STATUS, 32'h0E, "ill_status");
        bus_rd(0, A_RES_LO, 32'hFFFF_FFFF, "ill_lo_kept");
        bus_rd(0, A_RES_HI, 32'd42, "ill_hi_kept");
        bus_wr(0, A_STATUS, 32'd0);
        bus_rd(0, A_STATUS, 32'h00, "status_clear3");

        bus_rdwr(0, A_OPA, 32'h55, 32'd42, "rw_same_cycle");
        bus_rd(0, A_OPA, 32'h55, "rw_new_value");
        bus_rd(0, 3'd7, 32'd0, "reserved_read");

        bus_wr(0, A_OPA, 32'd3);
        bus_wr(0, A_OPB, 32'd5);
        bus_wr(0, A_OP, 32'd5);
        repeat (10) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) bus_rd(0, 3'(a), 32'd0, "post_reset_read");
        exp_irq(1'b0, "post_reset_irq");
        bus_wr(0, A_OPA, 32'd1);
        bus_wr(0, A_OPB, 32'd2);
        bus_wr(0, A_OP, 32'd0);
        bus_rd(0, A_RES_LO, 32'd3, "post_reset_add");
        bus_rd(0, A_STATUS, 32'h02, "post_reset_status");

        bus_wr(1, A_OPA, 32'h1FF);
        bus_rd(1, A_OPA, 32'hFF, "w8_trunc");
        bus_wr(1, A_OPB, 32'hFF);
        bus_wr(1, A_OP, 32'd5);
        for (int i = 0; i < 8; i++) bus_rd(1, A_STATUS, 32'h01, "w8_busy");
        bus_rd(1, A_STATUS, 32'h02, "w8_done");
        bus_rd(1, A_RES_LO, 32'h01, "w8_mul_lo");
        bus_rd(1, A_RES_HI, 32'hFE, "w8_mul_hi");

        repeat (4) step();
        stim_done = 1'b1;
    end

endmodule
